// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues single-outstanding word fetches, buffers returned
// words in a small FIFO and hands {pc, instr} to decode over a valid/ready handshake.
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [XLEN-1:0] i_imem_data,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [6:0]      o_op
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic {ST_FETCH, ST_DROP} state_t;

  state_t            state_reg, state_next;
  logic [XLEN-1:0]   pc_reg, pc_next;
  logic [XLEN-1:0]   addr_reg, addr_next;
  logic              pending_reg, pending_next;
  logic              run_reg;
  logic [AW:0]       count_reg, count_next;
  logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;

  logic [XLEN-1:0]   mem_pc    [DEPTH];
  logic [XLEN-1:0]   mem_instr [DEPTH];

  logic              start;
  logic              req;
  logic              ack_ok;
  logic              push;
  logic              pop;
  logic              fifo_nonempty;
  logic [XLEN-1:0]   cur_addr;
  logic              unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

  // run_reg holds off the first request until the cycle after reset is released.
  assign fifo_nonempty = (count_reg != '0);
  assign start    = run_reg && (state_reg == ST_FETCH) && !pending_reg && (count_reg != DEPTH_C);
  assign req      = pending_reg || start;
  assign cur_addr = pending_reg ? addr_reg : pc_reg;
  assign ack_ok   = req && i_imem_ack;
  assign push     = ack_ok && (state_reg == ST_FETCH) && !i_redirect;
  assign pop      = fifo_nonempty && i_ready && !i_redirect;

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    addr_next    = start ? pc_reg : addr_reg;
    pending_next = req && !i_imem_ack;
    count_next   = count_reg;
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;

    if (i_redirect) begin
      // An unanswered request must still be drained; its data belongs to the old path.
      pc_next     = {i_redirect_pc[XLEN-1:2], 2'b00};
      state_next  = (req && !i_imem_ack) ? ST_DROP : ST_FETCH;
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (push) begin
        pc_next     = pc_reg + XLEN'(4);
        wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      if ((state_reg == ST_DROP) && ack_ok) begin
        state_next = ST_FETCH;
      end
      unique case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= ST_FETCH;
      pc_reg      <= RESET_PC;
      addr_reg    <= RESET_PC;
      pending_reg <= 1'b0;
      run_reg     <= 1'b0;
      count_reg   <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      addr_reg    <= addr_next;
      pending_reg <= pending_next;
      run_reg     <= 1'b1;
      count_reg   <= count_next;
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_pc[wr_ptr_reg]    <= cur_addr;
      mem_instr[wr_ptr_reg] <= i_imem_data;
    end
  end

  assign o_imem_req  = req;
  assign o_imem_addr = cur_addr;
  assign o_valid     = fifo_nonempty;
  // Head entry is forced to zero while empty so stale storage never leaks out.
  assign o_instr     = fifo_nonempty ? mem_instr[rd_ptr_reg] : '0;
  assign o_pc        = fifo_nonempty ? mem_pc[rd_ptr_reg]    : '0;
  assign o_op        = o_instr[6:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: variable-latency memory model, redirect injection and
// a scoreboard of expected {pc, instr} entries compared as decode consumes them.
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_data;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [6:0]  o_op;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_instr(o_instr), .o_pc(o_pc), .o_op(o_op)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t sb[$];

  int checks = 0;
  int failures = 0;

  int          lat = 1;
  bit          tb_ready = 1'b1;
  int          redir_mode = 0;
  logic [31:0] redir_match, redir_target;
  bit          redir_fired = 1'b0;
  bit          mem_busy = 1'b0, mem_stale = 1'b0;
  int          mem_wait = 0;
  logic [31:0] mem_addr = '0;
  logic [31:0] exp_pc = RESET_PC;
  int          starts = 0;
  logic [31:0] last_start_addr = '0;
  logic [31:0] start_log[$];
  int          cyc = 0, prev_ack_cyc = 0, ack_gap = 0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample outputs, run the memory/redirect/decode model, drive inputs.
  task automatic cycle();
    bit   ack, redir;
    ent_t e;
    @(posedge i_clk);
    #1;
    cyc++;
    check_eq("valid", o_valid, (sb.size() != 0));
    if (mem_busy) begin
      check_eq("req_hold", o_imem_req, 1);
      check_eq("addr_hold", o_imem_addr, mem_addr);
    end else if (o_imem_req) begin
      mem_busy = 1'b1; mem_stale = 1'b0; mem_addr = o_imem_addr; mem_wait = lat;
      starts++; last_start_addr = o_imem_addr; start_log.push_back(o_imem_addr);
      check_eq("start_addr", o_imem_addr, exp_pc);
    end
    ack = 1'b0;
    if (mem_busy && mem_wait == 0) ack = 1'b1;
    else if (mem_busy) mem_wait--;
    redir = 1'b0;
    case (redir_mode)
      1: redir = mem_busy && !ack && (mem_addr == redir_match);
      2: redir = ack && (mem_addr == redir_match);
      3: redir = 1'b1;
      default: redir = 1'b0;
    endcase
    if (redir) begin redir_mode = 0; redir_fired = 1'b1; end
    i_imem_ack    = ack;
    i_imem_data   = ack ? data_of(mem_addr) : $urandom;
    i_redirect    = redir;
    i_redirect_pc = redir ? redir_target : $urandom;
    i_ready       = tb_ready;
    if (o_valid && tb_ready && !redir && sb.size() != 0) begin
      e = sb.pop_front();
      check_eq("pc", o_pc, e.pc);
      check_eq("instr", o_instr, e.instr);
      check_eq("op", {25'd0, o_op}, {25'd0, e.instr[6:0]});
    end
    if (redir) begin
      sb.delete();
      exp_pc = {redir_target[31:2], 2'b00};
    end else if (ack && !mem_stale) begin
      sb.push_back('{pc: mem_addr, instr: data_of(mem_addr)});
      exp_pc = mem_addr + 32'd4;
      ack_gap = cyc - prev_ack_cyc;
      prev_ack_cyc = cyc;
    end
    if (ack) mem_busy = 1'b0;
    else if (redir && mem_busy) mem_stale = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_starts(input string tag, input int target, input int budget);
    int n = 0;
    while (starts < target && n < budget) begin cycle(); n++; end
    check_eq(tag, (starts >= target), 1);
  endtask

  task automatic wait_fired(input string tag, input int budget);
    int n = 0;
    while (!redir_fired && n < budget) begin cycle(); n++; end
    check_eq(tag, redir_fired, 1);
  endtask

  initial begin
    int s0, n;
    i_rst_n = 1'b0; i_imem_ack = 1'b0; i_imem_data = '0;
    i_redirect = 1'b0; i_redirect_pc = '0; i_ready = 1'b1;
    #2;
    check_eq("rst_req", o_imem_req, 0);
    check_eq("rst_addr", o_imem_addr, RESET_PC);
    check_eq("rst_valid", o_valid, 0);
    check_eq("rst_instr", o_instr, 0);
    check_eq("rst_pc", o_pc, 0);
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    // 1: streaming with 1-cycle latency
    lat = 1; tb_ready = 1'b1;
    wait_starts("t1_starts", 6, 40);
    check_eq("t1_addr6", last_start_addr, 32'h14);
    run(4);
    check_eq("t1_gap", ack_gap, 2);

    // 2: decode stalled, FIFO fills to DEPTH and requests stop
    tb_ready = 1'b0;
    run(10);
    check_eq("t2_req_off", o_imem_req, 0);
    check_eq("t2_fill", sb.size(), DEPTH);
    check_eq("t2_valid", o_valid, 1);
    tb_ready = 1'b1;
    run(8);

    // 3: redirect while fetch of 0x8 is outstanding
    redir_target = 32'h0; redir_fired = 1'b0; redir_mode = 3;
    run(1);
    lat = 3; redir_match = 32'h8; redir_target = 32'h100; redir_fired = 1'b0; redir_mode = 1;
    wait_fired("t3_fired", 40);
    s0 = starts;
    wait_starts("t3_next", s0 + 1, 20);
    check_eq("t3_addr", last_start_addr, 32'h100);

    // 4: redirect coincident with ack, unaligned target
    lat = 2; redir_match = 32'h108; redir_target = 32'h203; redir_fired = 1'b0; redir_mode = 2;
    wait_fired("t4_fired", 40);
    s0 = starts;
    cycle();
    check_eq("t4_flush_valid", o_valid, 0);
    wait_starts("t4_next", s0 + 1, 20);
    check_eq("t4_addr", last_start_addr, 32'h200);
    run(6);

    // 5: zero-latency memory, simultaneous push/pop, PC wrap
    lat = 0; redir_target = 32'hFFFF_FFF4; redir_fired = 1'b0; redir_mode = 3;
    run(1);
    start_log.delete();
    s0 = starts;
    wait_starts("t5_starts", s0 + 4, 20);
    check_eq("t5_a0", start_log[0], 32'hFFFF_FFF4);
    check_eq("t5_a1", start_log[1], 32'hFFFF_FFF8);
    check_eq("t5_a2", start_log[2], 32'hFFFF_FFFC);
    check_eq("t5_a3", start_log[3], 32'h0000_0000);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq("t5_steady_valid", o_valid, 1);
    end

    // 6: reset asserted mid-request, stray ack after release
    lat = 3;
    n = 0;
    while (!mem_busy && n < 20) begin cycle(); n++; end
    check_eq("t6_busy", mem_busy, 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_eq("t6_req", o_imem_req, 0);
    check_eq("t6_addr", o_imem_addr, RESET_PC);
    check_eq("t6_valid", o_valid, 0);
    check_eq("t6_instr", o_instr, 0);
    check_eq("t6_pc", o_pc, 0);
    mem_busy = 1'b0; mem_stale = 1'b0; sb.delete(); exp_pc = RESET_PC;
    i_imem_ack = 1'b0; i_redirect = 1'b0;
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    i_imem_ack = 1'b1; i_imem_data = 32'hDEAD_BEEF;
    s0 = starts;
    wait_starts("t6_next", s0 + 1, 20);
    check_eq("t6_first_addr", last_start_addr, RESET_PC);
    run(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
